// File: rtl/gate_selftest_ctrl_pkg.sv
// Shared types and constants for the 2-input gate truth-table self-test.
package gate_selftest_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_DRIVE  = 3'd1,
        ST_SETTLE = 3'd2,
        ST_SAMPLE = 3'd3,
        ST_DONE   = 3'd4
    } state_t;

    localparam int NUM_VEC = 4;
    localparam int VEC_W   = $clog2(NUM_VEC);
    localparam int CNT_W   = $clog2(NUM_VEC + 1);

    typedef logic [VEC_W-1:0]   vec_t;
    typedef logic [CNT_W-1:0]   cnt_t;
    typedef logic [NUM_VEC-1:0] tt_t;

    localparam vec_t LAST_VEC = vec_t'(NUM_VEC - 1);

    localparam tt_t NAND2_TT = 4'b0111;
    localparam tt_t AND2_TT  = 4'b1000;
    localparam tt_t OR2_TT   = 4'b1110;
    localparam tt_t XOR2_TT  = 4'b0110;

    // Expected gate output for vector v, where v = {a,b}.
    function automatic logic tt_bit(input tt_t tt, input vec_t v);
        return tt[v];
    endfunction

endpackage

// File: rtl/gate_selftest_ctrl_if.sv
// Gate-side and status signals of the self-test controller.
// Optional loop_en input exists only when GATE_SELFTEST_LOOP_EN is defined.
interface gate_selftest_ctrl_if;
    logic       start;
    logic       gate_x;
    logic       gate_a;
    logic       gate_b;
    logic       busy;
    logic       done;
    logic       pass;
    logic [2:0] err_cnt;
    logic [3:0] fail_vec;
`ifdef GATE_SELFTEST_LOOP_EN
    logic       loop_en;
`endif

    modport master (
        output gate_a, gate_b, busy, done, pass, err_cnt, fail_vec,
        input  start, gate_x
`ifdef GATE_SELFTEST_LOOP_EN
        , input loop_en
`endif
    );

    modport slave (
        input  gate_a, gate_b, busy, done, pass, err_cnt, fail_vec,
        output start, gate_x
`ifdef GATE_SELFTEST_LOOP_EN
        , output loop_en
`endif
    );
endinterface

// File: rtl/gate_selftest_ctrl_settle_timer.sv
// Loadable down-counter timing how long gate inputs are held before sampling.
module settle_timer #(
    parameter int SETTLE_CYCLES = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    input  logic dec,
    output logic zero
);
    // Holds at most SETTLE_CYCLES-1.
    localparam int W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

    logic [W-1:0] cnt_q;

    always_ff @(posedge clk) begin
        if (rst)
            cnt_q <= '0;
        else if (load)
            cnt_q <= W'(SETTLE_CYCLES - 1);
        else if (dec && cnt_q != '0)
            cnt_q <= cnt_q - W'(1);
    end

    assign zero = (cnt_q == '0);
endmodule

// File: rtl/gate_selftest_ctrl.sv
// Truth-table sequencer: drives a 2-input gate through 00,01,10,11, samples and scores it.
// Build option GATE_SELFTEST_LOOP_EN adds loop_en for continuous back-to-back runs.
module gate_selftest_ctrl
    import gate_selftest_pkg::*;
#(
    parameter int  SETTLE_CYCLES = 4,
    parameter tt_t EXPECT        = NAND2_TT
) (
    input  logic                 clk,
    input  logic                 rst,
    gate_selftest_ctrl_if.master bus
);
    state_t state_q, state_d;
    vec_t   vec_q, vec_d;
    cnt_t   err_q, err_d;
    tt_t    fail_q, fail_d;
    logic   pass_q, pass_d;
    logic   tmr_load, tmr_dec, tmr_zero;
    logic   drv;

    settle_timer #(.SETTLE_CYCLES(SETTLE_CYCLES)) u_timer (
        .clk  (clk),
        .rst  (rst),
        .load (tmr_load),
        .dec  (tmr_dec),
        .zero (tmr_zero)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            vec_q   <= '0;
            err_q   <= '0;
            fail_q  <= '0;
            pass_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            vec_q   <= vec_d;
            err_q   <= err_d;
            fail_q  <= fail_d;
            pass_q  <= pass_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        vec_d    = vec_q;
        err_d    = err_q;
        fail_d   = fail_q;
        pass_d   = pass_q;
        tmr_load = 1'b0;
        tmr_dec  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    state_d = ST_DRIVE;
                    vec_d   = '0;
                    err_d   = '0;
                    fail_d  = '0;
                end
            end
            ST_DRIVE: begin
                tmr_load = 1'b1;
                state_d  = ST_SETTLE;
            end
            ST_SETTLE: begin
                if (tmr_zero) state_d = ST_SAMPLE;
                else          tmr_dec = 1'b1;
            end
            ST_SAMPLE: begin
                if (bus.gate_x != tt_bit(EXPECT, vec_q)) begin
                    fail_d[vec_q] = 1'b1;
                    err_d         = err_q + cnt_t'(1);
                end
                // pass is taken from the final count so it is valid during the done pulse
                if (vec_q == LAST_VEC) begin
                    state_d = ST_DONE;
                    pass_d  = (err_d == '0);
                end else begin
                    vec_d   = vec_q + vec_t'(1);
                    state_d = ST_DRIVE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
`ifdef GATE_SELFTEST_LOOP_EN
                if (bus.loop_en) begin
                    state_d = ST_DRIVE;
                    vec_d   = '0;
                    err_d   = '0;
                    fail_d  = '0;
                end
`endif
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign drv          = (state_q == ST_DRIVE) || (state_q == ST_SETTLE) || (state_q == ST_SAMPLE);
    assign bus.gate_a   = drv & vec_q[1];
    assign bus.gate_b   = drv & vec_q[0];
    assign bus.busy     = drv;
    assign bus.done     = (state_q == ST_DONE);
    assign bus.pass     = pass_q;
    assign bus.err_cnt  = err_q;
    assign bus.fail_vec = fail_q;
endmodule
